sha3_padder: RTL

SHA3_PADDER -- requirements
Module: sha3_padder

---
 rtl/sha3_pkg.sv | 17 +
 rtl/sha3_pad_word.sv | 27 ++
 rtl/sha3_padder.sv | 116 +++++++++++
 3 files changed

// File: rtl/sha3_pkg.sv
// Shared constants and state encoding for the SHA3-256 rate-block padder.
package sha3_pkg;

    localparam int RATE_BITS  = 1088;
    localparam int RATE_BYTES = 136;
    localparam int RATE_WORDS = 17;

    localparam logic [7:0] PAD_DOMAIN = 8'h06;
    localparam logic [7:0] PAD_FINAL  = 8'h80;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        SEND = 2'd1,
        PADX = 2'd2
    } pad_state_t;

endpackage

// File: rtl/sha3_pad_word.sv
// Masks the final message word to its valid bytes and inserts the domain pad byte.
module sha3_pad_word
    import sha3_pkg::*;
(
    input  logic [63:0] din,
    input  logic [3:0]  din_bytes,
    output logic [63:0] word,
    output logic        full
);

    logic [3:0] nbytes;

    // NOTE: every output is given a default before any condition, so no latch is inferred.
    always_comb begin
        nbytes = (din_bytes > 4'd8) ? 4'd8 : din_bytes;
        full   = (nbytes == 4'd8);
        word   = '0;
        for (int j = 0; j < 8; j++) begin
            if (j < int'(nbytes)) begin
                word[8*j +: 8] = din[8*j +: 8];
            end else if (j == int'(nbytes)) begin
                word[8*j +: 8] = PAD_DOMAIN;
            end
        end
    end

endmodule

// File: rtl/sha3_padder.sv
// Packs 64-bit message words into 1088-bit rate blocks and applies SHA3 pad10*1.
module sha3_padder
    import sha3_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [63:0]          din,
    input  logic                 din_valid,
    input  logic                 din_last,
    input  logic [3:0]           din_bytes,
    output logic                 din_ready,
    output logic [RATE_BITS-1:0] in,
    output logic                 in_valid,
    output logic                 more,
    input  logic                 hash_next
);

    localparam logic [4:0] LAST_SLOT = 5'(RATE_WORDS - 1);

    pad_state_t           state, state_nxt;
    logic [4:0]           word_cnt, cnt_nxt;
    logic [RATE_BITS-1:0] buffer, buf_nxt;
    logic                 more_nxt;
    logic                 pend, pend_nxt;
    logic [63:0]          pad_word;
    logic                 pad_full;
    logic                 accept;

    sha3_pad_word u_pad_word (
        .din       (din),
        .din_bytes (din_bytes),
        .word      (pad_word),
        .full      (pad_full)
    );

    assign din_ready = rst_n && (state == FILL);
    assign accept    = din_valid && din_ready;
    assign in        = buffer;
    assign in_valid  = (state == SEND);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = word_cnt;
        buf_nxt   = buffer;
        more_nxt  = more;
        pend_nxt  = pend;
        case (state)
            FILL: begin
                if (accept) begin
                    if (!din_last) begin
                        buf_nxt[{word_cnt, 6'd0} +: 64] = din;
                        if (word_cnt == LAST_SLOT) begin
                            state_nxt = SEND;
                            more_nxt  = 1'b1;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = word_cnt + 5'd1;
                        end
                    end else if (pad_full && word_cnt == LAST_SLOT) begin
                        // Block is exactly full: ship it as-is, padding goes in its own block.
                        buf_nxt[{word_cnt, 6'd0} +: 64] = din;
                        state_nxt = SEND;
                        more_nxt  = 1'b1;
                        pend_nxt  = 1'b1;
                        cnt_nxt   = '0;
                    end else begin
                        buf_nxt[{word_cnt, 6'd0} +: 64] = pad_word;
                        if (pad_full) begin
                            buf_nxt[{word_cnt + 5'd1, 6'd0} +: 8] = PAD_DOMAIN;
                        end
                        buf_nxt[RATE_BITS-1 -: 8] = buf_nxt[RATE_BITS-1 -: 8] | PAD_FINAL;
                        state_nxt = SEND;
                        more_nxt  = 1'b0;
                        cnt_nxt   = '0;
                    end
                end
            end
            SEND: begin
                if (hash_next) begin
                    buf_nxt   = '0;
                    more_nxt  = 1'b0;
                    pend_nxt  = 1'b0;
                    state_nxt = pend ? PADX : FILL;
                end
            end
            PADX: begin
                buf_nxt                   = '0;
                buf_nxt[7:0]              = PAD_DOMAIN;
                buf_nxt[RATE_BITS-1 -: 8] = PAD_FINAL;
                more_nxt                  = 1'b0;
                state_nxt                 = SEND;
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments; the wide buffer is reset too, since unwritten slots must read as zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FILL;
            word_cnt <= '0;
            buffer   <= '0;
            more     <= 1'b0;
            pend     <= 1'b0;
        end else begin
            state    <= state_nxt;
            word_cnt <= cnt_nxt;
            buffer   <= buf_nxt;
            more     <= more_nxt;
            pend     <= pend_nxt;
        end
    end

endmodule
